logic_cir_pipe: RTL and testbench
=================================

# logic_cir_pipe

Parametrised, pipelined successor to the team's two-level gate circuit: computes per-bit AND, NOR, XOR or the composite (a&b) ^ ~(c|d) across WIDTH-bit operands. Two register stages with a valid/ready handshake and full backpressure. Counts delivered results. Sits between operand producers and any downstream consumer that may stall.

## Interface
- WIDTH, 4: operand and result width in bits (≥1).
- CNT_W, 8: width of the delivered-result counter.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low; sampled on clk rising edge.
- in_valid  in  1  operand set and op valid.
- in_ready  out  1  block accepts operands this cycle.
- a, b, c, d  in  WIDTH each  operands.
- op  in  2  0=AND(a,b), 1=NOR(c,d), 2=XOR(a,b), 3=CIR ((a&b) ^ ~(c|d)).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result this cycle.
- o  out  WIDTH  result.
- cnt  out  CNT_W  number of results delivered (out_valid & out_ready), mod 2^CNT_W.
- o_par  out  1  XOR-reduction of o (only with LOGIC_CIR_PARITY_EN).

## Operation
- Transfer in: in_valid & in_ready on a rising edge. Transfer out: out_valid & out_ready on a rising edge.
- Stage 1 (S1) registers p = a&b, q = ~(c|d), x = a^b (all WIDTH), op, and s1_valid.
- Stage 2 (S2) registers o by op: 0→p, 1→q, 2→x, 3→p^q; and out_valid.
- Bitwise only: no carries, no cross-bit terms; bit i of o depends only on bit i of the operands.
- Advance rules: S2 loads when s1_valid & (~out_valid | out_ready). S1 loads when in_valid & in_ready.
- in_ready = ~s1_valid | ~out_valid | out_ready (combinational; no skid buffer).
- When stalled (out_valid & ~out_ready), o, out_valid, S1 contents hold stable.
- s1_valid clears when S1 moves to S2 with no new input; out_valid clears on out transfer with no S1 data.
- cnt increments by 1 on every out transfer. It wraps from 2^CNT_W−1 to 0 with no flag.
- op is captured with operands in S1. Changing op while a result is in flight does not affect that result.

## Timing
- Reset (rst_n=0 at edge): s1_valid=0, out_valid=0, o=0, cnt=0, S1 data=0. in_ready reads 1 during and after reset. o_par=0.
- Reset overrides any in-flight transfer. Data in S1/S2 is discarded. An out transfer on the reset edge does not increment cnt.
- Latency: input accepted at edge N → out_valid=1 with result after edge N+1 (visible in cycle N+1..N+2, two register stages).
- Throughput: 1 result/cycle with out_ready held high.
- Full pipeline with out_ready=0: in_ready=0. Both stages hold.
- Simultaneous out transfer and S1→S2 move on the same edge: o replaced, out_valid stays 1, cnt increments.
- Simultaneous in transfer and S1→S2 move: S1 takes new data, s1_valid stays 1.

## Configuration
- LOGIC_CIR_PARITY_EN defined: o_par port exists and is registered alongside o as ^o_next. It holds with o under stall and resets to 0.
- Undefined: o_par port and its register are absent. All other behaviour is identical.

## Test plan
- Reset, then WIDTH=4, op=3, a=b=c=d swept over all 16 patterns of {a,b,c,d} bit-replicated (e.g. a=4'hF,b=4'hF,c=0,d=0 → o=4'h0; a=b=c=d=0 → o=4'hF). With out_ready=1, each result appears 2 edges after acceptance and cnt=16 at end.
- Per-op check: a=4'b1100, b=4'b1010, c=4'b0011, d=4'b0001. op0→1000, op1→1100, op2→0110, op3→0100.
- Backpressure: stream 5 inputs with out_ready=0. in_ready drops after 2 accepted, o holds the first result. Release out_ready and all 5 results emerge in order, no loss or duplication, cnt=5.
- Wrap: CNT_W=3, deliver 9 results → cnt=1.
- Mid-operation reset: 2 results in flight, rst_n=0 for one edge → out_valid=0, cnt=0, o=0. Next accepted input yields a correct result after 2 edges.
- With LOGIC_CIR_PARITY_EN: o=4'b0111 → o_par=1, o=4'b0110 → o_par=0. Without it, the build has no o_par port.

Source files
------------

// File: rtl/logic_cir_pipe_if.sv
// rtl/logic_cir_pipe_if.sv - operand/result handshake bundle for logic_cir_pipe
interface logic_cir_pipe_if #(
  parameter int WIDTH = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] o;

  // Producer/consumer side: drives operands and out_ready, observes results.
  modport master (
    output in_valid, a, b, c, d, op, out_ready,
    input  in_ready, out_valid, o
  );

  // Pipeline side.
  modport slave (
    input  in_valid, a, b, c, d, op, out_ready,
    output in_ready, out_valid, o
  );
endinterface

// File: rtl/logic_cir_pipe.sv
// rtl/logic_cir_pipe.sv - two-stage bitwise AND/NOR/XOR/CIR pipeline; optional LOGIC_CIR_PARITY_EN adds o_par
module logic_cir_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  logic_cir_pipe_if.slave  bus,
  output logic [CNT_W-1:0] cnt
`ifdef LOGIC_CIR_PARITY_EN
  ,
  output logic             o_par
`endif
);

  // Stage 1 holds the three partial terms so stage 2 only has to select.
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s1_x;
  logic [1:0]       s1_op;
  logic             s1_valid;

  logic [WIDTH-1:0] o_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] o_next;

  logic s1_load;
  logic s2_load;
  logic out_xfer;
  logic ready_int;

  assign out_xfer  = out_valid_q & bus.out_ready;
  assign s2_load   = s1_valid & (~out_valid_q | bus.out_ready);
  // No skid buffer: S1 can only take new data if it is empty or will drain this edge.
  assign ready_int = ~s1_valid | ~out_valid_q | bus.out_ready;
  assign s1_load   = bus.in_valid & ready_int;

  // While reset is held the pipeline is being emptied, so advertise ready.
  assign bus.in_ready  = ~rst_n | ready_int;
  assign bus.out_valid = out_valid_q;
  assign bus.o         = o_q;

  // Select the stage-2 result from the captured op.
  always_comb begin
    o_next = '0;
    case (s1_op)
      2'd0:    o_next = s1_p;
      2'd1:    o_next = s1_q;
      2'd2:    o_next = s1_x;
      default: o_next = s1_p ^ s1_q;
    endcase
  end

  // Stage 1: capture partial terms and op on input transfer; empty when drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_p     <= '0;
      s1_q     <= '0;
      s1_x     <= '0;
      s1_op    <= '0;
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_p     <= bus.a & bus.b;
      s1_q     <= ~(bus.c | bus.d);
      s1_x     <= bus.a ^ bus.b;
      s1_op    <= bus.op;
      s1_valid <= 1'b1;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: result register; holds under stall, clears valid after delivery.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_q         <= '0;
      out_valid_q <= 1'b0;
    end else if (s2_load) begin
      o_q         <= o_next;
      out_valid_q <= 1'b1;
    end else if (out_xfer) begin
      out_valid_q <= 1'b0;
    end
  end

  // Delivered-result counter, wraps silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (out_xfer) begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef LOGIC_CIR_PARITY_EN
  // Parity travels with o so it is stable exactly when o is.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_par <= 1'b0;
    end else if (s2_load) begin
      o_par <= ^o_next;
    end
  end
`endif

endmodule

// File: tb/tb_logic_cir_pipe.sv
// tb/tb_logic_cir_pipe.sv - scoreboard bench for logic_cir_pipe
module tb_logic_cir_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] cnt;
  logic [2:0] w_cnt;
`ifdef LOGIC_CIR_PARITY_EN
  logic o_par;
  logic w_o_par;
`endif

  logic_cir_pipe_if #(.WIDTH(4)) bus ();
  logic_cir_pipe_if #(.WIDTH(4)) w_bus ();

  always #5 clk = ~clk;

  logic_cir_pipe #(.WIDTH(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .cnt   (cnt)
`ifdef LOGIC_CIR_PARITY_EN
    ,
    .o_par (o_par)
`endif
  );

  logic_cir_pipe #(.WIDTH(4), .CNT_W(3)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (w_bus),
    .cnt   (w_cnt)
`ifdef LOGIC_CIR_PARITY_EN
    ,
    .o_par (w_o_par)
`endif
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] o;
    int         t;
  } exp_t;

  exp_t q[$];
  int   ncyc = 0;
  bit   chk_lat = 1'b0;

  function automatic logic [3:0] model(input logic [3:0] a, b, c, d, input logic [1:0] op);
    logic [3:0] r;
    case (op)
      2'd0:    r = a & b;
      2'd1:    r = ~(c | d);
      2'd2:    r = a ^ b;
      default: r = (a & b) ^ ~(c | d);
    endcase
    return r;
  endfunction

  // Scoreboard: push on input transfer, pop/compare on output transfer.
  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: o=%h delivered with no expected entry", bus.o);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (bus.o !== e.o) begin
            errors++;
            $display("FAIL sb_data: o=%h expected %h", bus.o, e.o);
          end
`ifdef LOGIC_CIR_PARITY_EN
          checks++;
          if (o_par !== ^e.o) begin
            errors++;
            $display("FAIL sb_parity: o_par=%b expected %b", o_par, ^e.o);
          end
`endif
          if (chk_lat) begin
            checks++;
            if (ncyc - e.t !== 2) begin
              errors++;
              $display("FAIL sb_latency: %0d cycles expected 2", ncyc - e.t);
            end
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_t n;
        n.o = model(bus.a, bus.b, bus.c, bus.d, bus.op);
        n.t = ncyc;
        q.push_back(n);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    w_bus.in_valid = 1'b0;
    w_bus.out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic send(input logic [3:0] a, b, c, d, input logic [1:0] op);
    int n = 0;
    bus.a = a; bus.b = b; bus.c = c; bus.d = d; bus.op = op;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.out_ready = 1'b1;
    while ((q.size() != 0 || bus.out_valid) && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = 4'hF; bus.b = 4'hF; bus.c = 4'h0; bus.d = 4'h0; bus.op = 2'd0;
    bus.out_ready = 1'b1;
    w_bus.in_valid = 1'b0;
    w_bus.out_ready = 1'b0;
    step();
    step();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready_during: got %b expected 1", bus.in_ready);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.o !== 4'h0) begin
      errors++;
      $display("FAIL reset_o: got %h expected 0", bus.o);
    end
    checks++;
    if (cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d expected 0", cnt);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready_after: got %b expected 1", bus.in_ready);
    end
`ifdef LOGIC_CIR_PARITY_EN
    checks++;
    if (o_par !== 1'b0) begin
      errors++;
      $display("FAIL reset_o_par: got %b expected 0", o_par);
    end
`endif
  endtask

  task automatic test_cir_sweep();
    do_reset();
    bus.out_ready = 1'b1;
    chk_lat = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = i[3:0];
      send({4{v[3]}}, {4{v[2]}}, {4{v[1]}}, {4{v[0]}}, 2'd3);
    end
    drain();
    chk_lat = 1'b0;
    checks++;
    if (cnt !== 8'd16) begin
      errors++;
      $display("FAIL sweep_cnt: got %0d expected 16", cnt);
    end
  endtask

  task automatic test_per_op();
    logic [3:0] req [4];
    req[0] = 4'b1000; req[1] = 4'b1100; req[2] = 4'b0110; req[3] = 4'b0100;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      bus.out_ready = 1'b0;
      send(4'b1100, 4'b1010, 4'b0011, 4'b0001, k[1:0]);
      bus.op = ~k[1:0];
      while (!bus.out_valid && n < 10) begin
        step();
        n++;
      end
      checks++;
      if (bus.o !== req[k] || !bus.out_valid) begin
        errors++;
        $display("FAIL per_op_%0d: o=%b valid=%b expected %b", k, bus.o, bus.out_valid, req[k]);
      end
      bus.out_ready = 1'b1;
      step();
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [3:0] first;
    do_reset();
    first = model(4'h1, 4'h3, 4'h0, 4'h0, 2'd0);
    send(4'h1, 4'h3, 4'h0, 4'h0, 2'd0);
    send(4'h7, 4'h2, 4'h1, 4'h8, 2'd1);
    bus.a = 4'h5; bus.b = 4'h9; bus.c = 4'h0; bus.d = 4'h0; bus.op = 2'd2;
    bus.in_valid = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready);
    end
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (bus.o !== first || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: o=%h valid=%b expected %h valid 1", bus.o, bus.out_valid, first);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    send(4'h5, 4'h9, 4'h0, 4'h0, 2'd2);
    send(4'hE, 4'h6, 4'h5, 4'h2, 2'd3);
    send(4'hA, 4'hF, 4'h3, 4'h3, 2'd0);
    drain();
    checks++;
    if (cnt !== 8'd5) begin
      errors++;
      $display("FAIL bp_cnt: got %0d expected 5", cnt);
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    do_reset();
    w_bus.a = 4'h3; w_bus.b = 4'h6; w_bus.c = 4'h0; w_bus.d = 4'h0; w_bus.op = 2'd2;
    w_bus.out_ready = 1'b1;
    w_bus.in_valid = 1'b1;
    for (int k = 0; k < 9; k++) step();
    w_bus.in_valid = 1'b0;
    while (w_bus.out_valid && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (w_cnt !== 3'd1) begin
      errors++;
      $display("FAIL wrap_cnt: got %0d expected 1", w_cnt);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send(4'hF, 4'hF, 4'h0, 4'h0, 2'd0);
    send(4'h0, 4'h0, 4'h0, 4'h0, 2'd1);
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || cnt !== 8'd0 || bus.o !== 4'h0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b cnt=%0d o=%h expected 0 0 0", bus.out_valid, cnt, bus.o);
    end
    send(4'b1100, 4'b1010, 4'b0011, 4'b0001, 2'd3);
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.o !== 4'b0100) begin
      errors++;
      $display("FAIL mid_reset_after: valid=%b o=%b expected 1 0100", bus.out_valid, bus.o);
    end
    drain();
    checks++;
    if (cnt !== 8'd1) begin
      errors++;
      $display("FAIL mid_reset_cnt: got %0d expected 1", cnt);
    end
  endtask

`ifdef LOGIC_CIR_PARITY_EN
  task automatic test_parity();
    do_reset();
    bus.out_ready = 1'b0;
    send(4'b0111, 4'b1111, 4'h0, 4'h0, 2'd0);
    step();
    checks++;
    if (o_par !== 1'b1) begin
      errors++;
      $display("FAIL parity_0111: got %b expected 1", o_par);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    send(4'b0110, 4'b1111, 4'h0, 4'h0, 2'd0);
    step();
    checks++;
    if (o_par !== 1'b0) begin
      errors++;
      $display("FAIL parity_0110: got %b expected 0", o_par);
    end
    drain();
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0; bus.op = '0;
    w_bus.in_valid = 1'b0;
    w_bus.out_ready = 1'b0;
    w_bus.a = '0; w_bus.b = '0; w_bus.c = '0; w_bus.d = '0; w_bus.op = '0;
    test_reset();
    test_cir_sweep();
    test_per_op();
    test_backpressure();
    test_wrap();
    test_mid_reset();
`ifdef LOGIC_CIR_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
